// File: rtl/nr_subtract.sv
// rtl/nr_subtract.sv - pipelined float32 CONST - Operand stage of the inverse square root datapath
module nr_subtract #(
    parameter logic [31:0] CONST = 32'h3FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] Operand,
    input  logic [31:0] Init_data_in,
    output logic [31:0] Difference,
    output logic [31:0] Init_data_out,
    output logic        Valid,
    output logic        ce_out
);

    logic [7:0]  c_exp;
    logic [23:0] c_man;
    logic [7:0]  x_exp;
    logic [23:0] x_man;
    logic        x_zero, x_special, x_neg, c_ge;
    logic [7:0]  a_exp, b_exp, exp_diff;
    logic [23:0] a_man, b_man;
    logic [4:0]  shamt;
    logic [26:0] b_ext, b_shifted, lost_mask;
    logic [26:0] b_aligned;
    logic        res_sign_s1;

    always_comb begin
        c_exp     = CONST[30:23];
        c_man     = {1'b1, CONST[22:0]};
        x_zero    = (Operand[30:23] == 8'd0);
        x_special = (Operand[30:23] == 8'hFF);
        // Zero and denormal operands collapse to +0 so the result is exactly CONST.
        x_exp     = x_zero ? 8'd0 : Operand[30:23];
        x_man     = x_zero ? 24'd0 : {1'b1, Operand[22:0]};
        x_neg     = Operand[31] & ~x_zero;
        c_ge      = ({c_exp, c_man} >= {x_exp, x_man});
        a_exp     = c_ge ? c_exp : x_exp;
        a_man     = c_ge ? c_man : x_man;
        b_exp     = c_ge ? x_exp : c_exp;
        b_man     = c_ge ? x_man : c_man;
        // When |Operand| wins, CONST - Operand takes the sign of -Operand.
        res_sign_s1 = c_ge ? 1'b0 : ~x_neg;
        exp_diff  = a_exp - b_exp;
        shamt     = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
        b_ext     = {b_man, 3'b000};
        b_shifted = b_ext >> shamt;
        lost_mask = (27'd1 << shamt) - 27'd1;
        b_aligned = {b_shifted[26:1], b_shifted[0] | (|(b_ext & lost_mask))};
    end

    logic [26:0] s1_a, s1_b;
    logic [7:0]  s1_exp;
    logic        s1_sign, s1_sub, s1_nan, v1;
    logic [31:0] s1_init;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_exp  <= '0;
            s1_sign <= 1'b0;
            s1_sub  <= 1'b0;
            s1_nan  <= 1'b0;
            s1_init <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= ce;
            if (ce) begin
                s1_a    <= {a_man, 3'b000};
                s1_b    <= b_aligned;
                s1_exp  <= a_exp;
                s1_sign <= res_sign_s1;
                s1_sub  <= ~x_neg;
                s1_nan  <= x_special;
                s1_init <= Init_data_in;
            end
        end
    end

    logic [27:0] s2_sum;
    logic [7:0]  s2_exp;
    logic        s2_sign, s2_nan, v2;
    logic [31:0] s2_init;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sum  <= '0;
            s2_exp  <= '0;
            s2_sign <= 1'b0;
            s2_nan  <= 1'b0;
            s2_init <= '0;
            v2      <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                s2_sum  <= s1_sub ? ({1'b0, s1_a} - {1'b0, s1_b})
                                  : ({1'b0, s1_a} + {1'b0, s1_b});
                s2_exp  <= s1_exp;
                s2_sign <= s1_sign;
                s2_nan  <= s1_nan;
                s2_init <= s1_init;
            end
        end
    end

    logic [4:0]        lz;
    logic [26:0]       norm_man;
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_frac;
    logic [31:0]       packed_res;

    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (s2_sum[i]) lz = 5'(26 - i);
        end
        norm_man = s2_sum[26:0] << lz;
        if (s2_sum[27]) begin
            norm_exp  = $signed({2'b00, s2_exp}) + 10'sd1;
            norm_frac = 23'(s2_sum >> 4);
        end else begin
            norm_exp  = $signed({2'b00, s2_exp}) - $signed({5'b00000, lz});
            norm_frac = 23'(norm_man >> 3);
        end
        // Guard/round/sticky are simply dropped: truncation toward zero.
        if (s2_nan)
            packed_res = 32'h7FC00000;
        else if (s2_sum == 28'd0)
            packed_res = 32'h00000000;
        else if (norm_exp <= 10'sd0)
            packed_res = {s2_sign, 31'd0};
        else if (norm_exp >= 10'sd255)
            packed_res = {s2_sign, 8'hFF, 23'd0};
        else
            packed_res = {s2_sign, norm_exp[7:0], norm_frac};
    end

    logic [31:0] s3_res, s3_init;
    logic        v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_res  <= '0;
            s3_init <= '0;
            v3      <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                s3_res  <= packed_res;
                s3_init <= s2_init;
            end
        end
    end

    // Output registers keep the ports free of combinational input paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            Difference    <= '0;
            Init_data_out <= '0;
            Valid         <= 1'b0;
            ce_out        <= 1'b0;
        end else begin
            ce_out <= v3;
            if (v3) begin
                Difference    <= s3_res;
                Init_data_out <= s3_init;
                Valid         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nr_subtract.sv
// tb/tb_nr_subtract.sv - directed self-checking bench for nr_subtract
module tb_nr_subtract;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] Operand = '0;
    logic [31:0] Init_data_in = '0;
    logic [31:0] Difference, Init_data_out;
    logic        Valid, ce_out;

    int n_assert = 0;
    int n_fail = 0;

    logic        h_ce [4];
    logic [31:0] h_d  [4];
    logic [31:0] h_i  [4];
    logic [31:0] last_d, last_i;
    logic        last_v;

    always #5 clk = ~clk;

    nr_subtract dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .Operand      (Operand),
        .Init_data_in (Init_data_in),
        .Difference   (Difference),
        .Init_data_out(Init_data_out),
        .Valid        (Valid),
        .ce_out       (ce_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            h_ce[i] = 1'b0;
            h_d[i]  = '0;
            h_i[i]  = '0;
        end
        last_d = '0;
        last_i = '0;
        last_v = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ce_out"}, {31'd0, ce_out}, {31'd0, last_v & h_ce[3]});
        check({tag, ".diff"}, Difference, last_d);
        check({tag, ".init"}, Init_data_out, last_i);
        check({tag, ".valid"}, {31'd0, Valid}, {31'd0, last_v});
    endtask

    // Apply one input cycle; the result expected three edges later is queued alongside it.
    task automatic tick(input string tag, input logic c, input logic [31:0] op,
                        input logic [31:0] ed, input logic [31:0] init);
        ce = c;
        Operand = op;
        Init_data_in = init;
        for (int i = 3; i > 0; i--) begin
            h_ce[i] = h_ce[i-1];
            h_d[i]  = h_d[i-1];
            h_i[i]  = h_i[i-1];
        end
        h_ce[0] = c;
        h_d[0]  = ed;
        h_i[0]  = init;
        @(posedge clk);
        #1;
        if (h_ce[3]) begin
            last_d = h_d[3];
            last_i = h_i[3];
            last_v = 1'b1;
        end
        check_outputs(tag);
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        ce = 1'b1;
        Operand = 32'h3F000000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ce = 1'b0;
        check_outputs("reset");

        tick("half", 1'b1, 32'h3F000000, 32'h3F800000, 32'h12345678);
        repeat (4) tick("half_idle", 1'b0, 32'hDEADBEEF, 32'h0, 32'h0);

        tick("eq",    1'b1, 32'h3FC00000, 32'h00000000, 32'hA0000001);
        tick("two",   1'b1, 32'h40000000, 32'hBF000000, 32'hA0000002);
        tick("near1", 1'b1, 32'h3F7FFFFF, 32'h3F000001, 32'hA0000003);
        tick("neg1",  1'b1, 32'hBF800000, 32'h40200000, 32'hA0000004);
        tick("trunc", 1'b1, 32'h33800001, 32'h3FBFFFFF, 32'hA0000005);
        tick("zero",  1'b1, 32'h00000000, 32'h3FC00000, 32'hA0000006);
        tick("denorm",1'b1, 32'h00000005, 32'h3FC00000, 32'hA0000007);
        tick("inf",   1'b1, 32'h7F800000, 32'h7FC00000, 32'hA0000008);
        repeat (4) tick("flush", 1'b0, 32'h3F800000, 32'h0, 32'h0);

        tick("pat1", 1'b1, 32'h3F000000, 32'h3F800000, 32'hB0000001);
        tick("pat0", 1'b0, 32'h40000000, 32'h0,        32'hFFFFFFFF);
        tick("pat1", 1'b1, 32'hBF800000, 32'h40200000, 32'hB0000003);
        tick("pat1", 1'b1, 32'h40000000, 32'hBF000000, 32'hB0000004);
        tick("pat0", 1'b0, 32'h3F000000, 32'h0,        32'hFFFFFFFF);
        repeat (4) tick("pat_idle", 1'b0, 32'h0, 32'h0, 32'h0);

        tick("inflight", 1'b1, 32'h3F000000, 32'h3F800000, 32'hC0000001);
        tick("inflight", 1'b1, 32'h40000000, 32'hBF000000, 32'hC0000002);
        tick("inflight", 1'b1, 32'hBF800000, 32'h40200000, 32'hC0000003);
        rst = 1'b1;
        ce = 1'b1;
        Operand = 32'h3F7FFFFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        check_outputs("midrst");
        repeat (5) tick("post_rst", 1'b0, 32'h3F000000, 32'h0, 32'h0);
        tick("restart", 1'b1, 32'h33800001, 32'h3FBFFFFF, 32'hD0000001);
        repeat (4) tick("restart_idle", 1'b0, 32'h0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nr_subtract.md
# nr_subtract

Pipelined float32 subtract stage of the fast inverse square root datapath. It sits directly downstream of the multiplication stage. It computes the Newton-Raphson correction term `CONST - Operand`, with `CONST` = 1.5 by default. The initial-guess word travels alongside the operand so the final multiply stage receives both aligned. Latency is three cycles. Throughput is one operand per clock, qualified by `ce`.

## Interface
- `CONST`, default 32'h3FC00000, positive normal float32 minuend (1.5).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ce`  in  1  input qualifier; `Operand`/`Init_data_in` sampled when high.
- `Operand`  in  32  float32 subtrahend (multiplication stage `Product`).
- `Init_data_in`  in  32  pass-through word (multiplication stage `Init_data`).
- `Difference`  out  32  float32 result `CONST - Operand`.
- `Init_data_out`  out  32  `Init_data_in` delayed 3 cycles, aligned with `Difference`.
- `Valid`  out  1  high when `Difference` holds a result produced since reset.
- `ce_out`  out  1  `ce` delayed 3 cycles; high for exactly the cycle a new result appears.

## Operation
- **Operand classification:**
  - Operand exponent 0 (zero or denormal) is treated as +0, so the result is `CONST`.
  - Operand exponent 255 (Inf or NaN) gives result 32'h7FC00000.
  - Operand sign is honoured. A negative operand becomes a magnitude add.
- **S1 (align):**
  - Unpack both values with the hidden 1.
  - Compare magnitudes and swap so A ≥ B. The result sign is the sign of the larger value.
  - Compute the exponent difference.
  - Right-shift the smaller mantissa into a 27-bit field (24 bits plus guard, round, sticky). Cap the shift at 26; shifted-out bits OR into sticky.
- **S2 (add/sub):**
  - Take the 28-bit sum or difference of the aligned mantissas, with a carry bit.
  - Forward the exponent, sign and special flags.
- **S3 (normalize and pack):**
  - On carry: shift right 1, exponent +1.
  - Otherwise: leading-zero count, then left-shift and decrement the exponent.
  - Rounding is truncation toward zero (guard/round/sticky dropped), matching the multiplication stage.
  - A zero mantissa yields +0 (32'h00000000).
  - Exponent ≤ 0 after normalization flushes to ±0.
  - Exponent ≥ 255 yields ±Inf.
- **Pipeline qualifiers:**
  - Per-stage valid bits v1..v3 follow `ce`. `ce_out` = v3.
  - `Difference` and `Init_data_out` load only when v3 = 1, and hold otherwise.
  - `Valid` sets on the first load after reset and stays high until `rst`.

## Timing
- **Reset:**
  - `Difference`, `Init_data_out`, `Valid`, `ce_out`, v1..v3 and all stage registers = 0.
  - Reset takes priority over `ce`.
  - Reset mid-stream discards in-flight operands; none emerge after `rst` deasserts.
- **Latency:** `ce` high with operand X at edge N gives `ce_out` = 1 and `Difference` = f(X) from edge N+3 until edge N+4.
- **Streaming:** back-to-back `ce` produces back-to-back results. `ce` gaps produce identical gaps on `ce_out`, with the outputs holding their last value.
- **Interface:** no backpressure; the downstream stage must accept every `ce_out` pulse.
- **Paths:** no combinational path from inputs to outputs.

## Test plan
- Operand 32'h3F000000 (0.5), `Init_data_in` 32'h12345678, `ce` pulse → 3 cycles later `Difference` = 32'h3F800000, `Init_data_out` = 32'h12345678, `ce_out` pulse of 1 cycle, `Valid` = 1.
- Operands 32'h3FC00000, 32'h40000000, 32'h3F7FFFFF, 32'hBF800000 on consecutive cycles → 32'h00000000, 32'hBF000000, 32'h3F000001, 32'h40200000 on consecutive cycles.
- Truncation check: operand 32'h33800001 → 32'h3FBFFFFF.
- Special cases:
  - Operand 32'h00000000 → 32'h3FC00000.
  - Operand 32'h00000005 (denormal) → 32'h3FC00000.
  - Operand 32'h7F800000 → 32'h7FC00000.
- Pattern `ce` = 1,0,1,1,0 → `ce_out` repeats 1,0,1,1,0 three cycles later; outputs hold during the 0 cycles.
- Assert `rst` for 1 cycle while 3 operands are in flight → all outputs 0 the next cycle, no `ce_out` pulses follow, `Valid` stays 0 until the next `ce`.
